// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    localparam int unsigned PC_W        = 32;
    localparam logic [31:0] NOP_BUBBLE  = 32'h0;
    localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, run/halt FSM
// and saturating stall/flush counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET   = 32'h0,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [PC_W-1:0] PC_LIMIT = PC_W'(4 * IMEM_DEPTH);

    state_t          state;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] target;
    logic            stall_inc;
    logic            flush_inc;

    assign imem_addr_o = pc_o;
    assign pc_next     = pc_o + WORD_STRIDE;
    assign target      = {branch_target_i[31:2], 2'b00};

    // A branch always wins over a stall, so only unbranched stalls are counted.
    assign stall_inc = start_i & ~branch_i & stall_i;
    assign flush_inc = start_i & branch_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            halted_o     <= 1'b0;
            pc_o         <= PC_RESET;
            ifid_pc_o    <= '0;
            ifid_instr_o <= NOP_BUBBLE;
            ifid_valid_o <= 1'b0;
        end else if (!start_i) begin
            if (state == RUN) begin
                state <= IDLE;
            end
        end else if (branch_i) begin
            pc_o         <= target;
            ifid_pc_o    <= '0;
            ifid_instr_o <= NOP_BUBBLE;
            ifid_valid_o <= 1'b0;
            if (target >= PC_LIMIT) begin
                state    <= HALT;
                halted_o <= 1'b1;
            end else begin
                state    <= RUN;
                halted_o <= 1'b0;
            end
        end else if (stall_i) begin
            if (state == IDLE) begin
                state <= RUN;
            end
        end else if (state == HALT) begin
            // Draining: downstream sees bubbles while the PC stays parked.
            ifid_pc_o    <= '0;
            ifid_instr_o <= NOP_BUBBLE;
            ifid_valid_o <= 1'b0;
        end else begin
            ifid_pc_o    <= pc_o;
            ifid_instr_o <= imem_data_i;
            ifid_valid_o <= 1'b1;
            pc_o         <= pc_next;
            if (pc_next >= PC_LIMIT) begin
                state    <= HALT;
                halted_o <= 1'b1;
            end else begin
                state    <= RUN;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (stall_inc),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .inc   (flush_inc),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a 256-word instance for fetch/stall/branch/reset
// and a 4-word, 2-bit-counter instance for halt and counter saturation.
module tb_fetch_stage;

    logic        clk;
    logic        rst;

    logic        start1, stall1, branch1;
    logic [31:0] target1;
    logic [31:0] addr1, data1, pc1, ifid_pc1, ifid_instr1;
    logic        ifid_valid1, halted1;
    logic [31:0] stall_cnt1, flush_cnt1;

    logic        start2, stall2, branch2;
    logic [31:0] target2;
    logic [31:0] addr2, data2, pc2, ifid_pc2, ifid_instr2;
    logic        ifid_valid2, halted2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    int unsigned n_vec;
    int unsigned n_bad;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    assign data1 = word_at(addr1);
    assign data2 = word_at(addr2);

    fetch_stage #(.PC_RESET(32'h0), .IMEM_DEPTH(256), .CNT_W(32)) dut1 (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start1),
        .stall_i         (stall1),
        .branch_i        (branch1),
        .branch_target_i (target1),
        .imem_addr_o     (addr1),
        .imem_data_i     (data1),
        .pc_o            (pc1),
        .ifid_pc_o       (ifid_pc1),
        .ifid_instr_o    (ifid_instr1),
        .ifid_valid_o    (ifid_valid1),
        .halted_o        (halted1),
        .stall_cnt_o     (stall_cnt1),
        .flush_cnt_o     (flush_cnt1)
    );

    fetch_stage #(.PC_RESET(32'h0), .IMEM_DEPTH(4), .CNT_W(2)) dut2 (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start2),
        .stall_i         (stall2),
        .branch_i        (branch2),
        .branch_target_i (target2),
        .imem_addr_o     (addr2),
        .imem_data_i     (data2),
        .pc_o            (pc2),
        .ifid_pc_o       (ifid_pc2),
        .ifid_instr_o    (ifid_instr2),
        .ifid_valid_o    (ifid_valid2),
        .halted_o        (halted2),
        .stall_cnt_o     (stall_cnt2),
        .flush_cnt_o     (flush_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        start1 = 1'b0; stall1 = 1'b0; branch1 = 1'b0; target1 = '0;
        start2 = 1'b0; stall2 = 1'b0; branch2 = 1'b0; target2 = '0;
        step();
        step();

        // reset values
        check("rst_pc",     pc1, 32'h0);
        check("rst_addr",   addr1, 32'h0);
        check("rst_ifpc",   ifid_pc1, 32'h0);
        check("rst_instr",  ifid_instr1, 32'h0);
        check("rst_valid",  {31'd0, ifid_valid1}, 32'd0);
        check("rst_halted", {31'd0, halted1}, 32'd0);
        check("rst_scnt",   stall_cnt1, 32'd0);
        check("rst_fcnt",   flush_cnt1, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        step();
        check("idle_hold_pc", pc1, 32'h0);

        // straight-line fetch
        start1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("run_pc%0d", k), pc1, 32'(4 * k));
            check($sformatf("run_instr%0d", k), ifid_instr1, word_at(32'(4 * (k - 1))));
            check($sformatf("run_ifpc%0d", k), ifid_pc1, 32'(4 * (k - 1)));
            check($sformatf("run_valid%0d", k), {31'd0, ifid_valid1}, 32'd1);
        end
        check("run_scnt", stall_cnt1, 32'd0);
        check("run_fcnt", flush_cnt1, 32'd0);

        // three-edge stall at pc=16
        stall1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("stall_pc%0d", k), pc1, 32'h10);
            check($sformatf("stall_instr%0d", k), ifid_instr1, word_at(32'hC));
            check($sformatf("stall_cnt%0d", k), stall_cnt1, 32'(k));
        end
        stall1 = 1'b0;
        step();
        check("resume_pc", pc1, 32'h14);
        check("resume_instr", ifid_instr1, word_at(32'h10));

        // branch with simultaneous stall
        branch1 = 1'b1; stall1 = 1'b1; target1 = 32'h40;
        step();
        check("br_pc", pc1, 32'h40);
        check("br_valid", {31'd0, ifid_valid1}, 32'd0);
        check("br_instr", ifid_instr1, 32'h0);
        check("br_ifpc", ifid_pc1, 32'h0);
        check("br_fcnt", flush_cnt1, 32'd1);
        check("br_scnt", stall_cnt1, 32'd3);
        branch1 = 1'b0; stall1 = 1'b0;
        step();
        check("br_tgt_instr", ifid_instr1, word_at(32'h40));
        check("br_tgt_ifpc", ifid_pc1, 32'h40);
        check("br_tgt_pc", pc1, 32'h44);

        // misaligned target is word-aligned
        branch1 = 1'b1; target1 = 32'h1B;
        step();
        check("mis_pc", pc1, 32'h18);
        check("mis_fcnt", flush_cnt1, 32'd2);
        branch1 = 1'b0;
        step();
        check("mis_instr", ifid_instr1, word_at(32'h18));
        step();
        check("mis_pc2", pc1, 32'h20);

        stall1 = 1'b1;
        step();
        step();
        check("st5_cnt", stall_cnt1, 32'd5);

        // start low: back to IDLE, nothing moves or counts
        start1 = 1'b0;
        step();
        check("stop_pc", pc1, 32'h20);
        check("stop_scnt", stall_cnt1, 32'd5);
        check("stop_instr", ifid_instr1, word_at(32'h1C));

        // asynchronous reset mid-cycle
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_pc",     pc1, 32'h0);
        check("arst_addr",   addr1, 32'h0);
        check("arst_ifpc",   ifid_pc1, 32'h0);
        check("arst_instr",  ifid_instr1, 32'h0);
        check("arst_valid",  {31'd0, ifid_valid1}, 32'd0);
        check("arst_halted", {31'd0, halted1}, 32'd0);
        check("arst_scnt",   stall_cnt1, 32'd0);
        check("arst_fcnt",   flush_cnt1, 32'd0);
        stall1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        start1 = 1'b1;
        step();
        check("post_pc", pc1, 32'h4);
        check("post_instr", ifid_instr1, word_at(32'h0));

        // out-of-range branch halts, in-range branch restarts
        branch1 = 1'b1; target1 = 32'h1000;
        step();
        check("oor_pc", pc1, 32'h1000);
        check("oor_halted", {31'd0, halted1}, 32'd1);
        check("oor_fcnt", flush_cnt1, 32'd1);
        branch1 = 1'b0;
        step();
        check("hlt_pc", pc1, 32'h1000);
        check("hlt_valid", {31'd0, ifid_valid1}, 32'd0);
        check("hlt_halted", {31'd0, halted1}, 32'd1);
        branch1 = 1'b1; target1 = 32'h8;
        step();
        check("rerun_pc", pc1, 32'h8);
        check("rerun_halted", {31'd0, halted1}, 32'd0);
        branch1 = 1'b0;
        step();
        check("rerun_instr", ifid_instr1, word_at(32'h8));
        start1 = 1'b0;

        // small memory: run off the end
        start2 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("sm_pc%0d", k), pc2, 32'(4 * k));
            check($sformatf("sm_halted%0d", k), {31'd0, halted2}, 32'd0);
        end
        step();
        check("sm_end_pc", pc2, 32'h10);
        check("sm_end_halted", {31'd0, halted2}, 32'd1);
        check("sm_end_instr", ifid_instr2, word_at(32'hC));
        check("sm_end_valid", {31'd0, ifid_valid2}, 32'd1);
        step();
        check("sm_drain_pc", pc2, 32'h10);
        check("sm_drain_valid", {31'd0, ifid_valid2}, 32'd0);
        check("sm_drain_instr", ifid_instr2, 32'h0);
        branch2 = 1'b1; target2 = 32'h4;
        step();
        check("sm_br_pc", pc2, 32'h4);
        check("sm_br_halted", {31'd0, halted2}, 32'd0);
        check("sm_br_fcnt", {30'd0, flush_cnt2}, 32'd1);
        branch2 = 1'b0;
        step();
        check("sm_br_instr", ifid_instr2, word_at(32'h4));
        check("sm_br_pc2", pc2, 32'h8);

        // 2-bit stall counter saturates at 3
        stall2 = 1'b1;
        step();
        step();
        check("sat_pre", {30'd0, stall_cnt2}, 32'd2);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("sat_cnt%0d", k), {30'd0, stall_cnt2}, 32'd3);
        end
        check("sat_pc", pc2, 32'h8);
        stall2 = 1'b0;
        start2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
